// File: rtl/seq_restoring_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master drives start and operands; the slave returns status and results.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             in_ready;
   logic             busy;
   logic             out_valid;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  in_ready,
      input  busy,
      input  out_valid,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output in_ready,
      output busy,
      output out_valid,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// fixed WIDTH-cycle latency, results held in DONE until the next accepted start.
module seq_restoring_divider #(
   parameter int WIDTH = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   seq_restoring_divider_if.slave    bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] prem_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             out_valid_q;

   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   diff_s;
   logic             qbit_s;
   logic [WIDTH-1:0] prem_d;
   logic [WIDTH-1:0] shift_d;
   logic             accept_s;

   assign accept_s = bus.start & in_ready_q;

   // One restoring step: subtract if it fits, otherwise keep the shifted trial.
   always_comb begin
      trial_s = {prem_q, shift_q[WIDTH-1]};
      diff_s  = trial_s - {1'b0, divisor_q};
      qbit_s  = ~diff_s[WIDTH];
      prem_d  = trial_s[WIDTH-1:0];
      if (qbit_s) begin
         prem_d = diff_s[WIDTH-1:0];
      end else begin
         prem_d = trial_s[WIDTH-1:0];
      end
      shift_d = {shift_q[WIDTH-2:0], qbit_s};
   end

   // Control FSM with datapath and registered status/result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= {WIDTH{1'b0}};
         divisor_q   <= {WIDTH{1'b0}};
         prem_q      <= {WIDTH{1'b0}};
         cnt_q       <= {CW{1'b0}};
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept_s) begin
                  state_q     <= ST_RUN;
                  shift_q     <= bus.dividend;
                  divisor_q   <= bus.divisor;
                  prem_q      <= {WIDTH{1'b0}};
                  cnt_q       <= CW'(WIDTH);
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q <= state_q;
               end
            end
            ST_RUN: begin
               shift_q <= shift_d;
               prem_q  <= prem_d;
               cnt_q   <= cnt_q - CW'(1);
               // Last iteration: publish the freshly computed step directly.
               if (cnt_q == CW'(1)) begin
                  state_q     <= ST_DONE;
                  quotient_q  <= shift_d;
                  remainder_q <= prem_d;
                  dbz_q       <= (divisor_q == {WIDTH{1'b0}});
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.busy        = busy_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against an arithmetic reference.
module tb_seq_restoring_divider;
   localparam int W    = 3;
   localparam int ONES = (1 << W) - 1;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   lat;

   seq_restoring_divider_if #(.WIDTH(W)) bus ();

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_q(input int a, input int b);
      return (b == 0) ? ONES : a / b;
   endfunction

   function automatic int ref_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.out_valid !== 1'b1 && n < 12);
   endtask

   task automatic check_result(input string tag, input int a, input int b);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_q"}, bus.quotient, ref_q(a, b));
      chk({tag, "_r"}, bus.remainder, ref_r(a, b));
      chk({tag, "_dbz"}, bus.div_by_zero, (b == 0) ? 1 : 0);
   endtask

   task automatic run_op(input string tag, input int a, input int b);
      int n;
      bus.start    = 1'b1;
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_accept_valid"}, bus.out_valid, 0);
      chk({tag, "_accept_busy"}, bus.busy, 1);
      chk({tag, "_accept_ready"}, bus.in_ready, 0);
      wait_done(n);
      chk({tag, "_latency"}, n, W);
      check_result(tag, a, b);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_q", bus.quotient, 0);
      chk("rst_r", bus.remainder, 0);
      chk("rst_dbz", bus.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      // 7/2 with busy visible for three cycles, then a ten-cycle hold
      bus.start = 1'b1; bus.dividend = 3'd7; bus.divisor = 3'd2;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < W; i++) begin
         chk("t1_busy", bus.busy, (i < W - 1) ? 1 : 1);
         if (i < W - 1) @(negedge clk);
      end
      @(negedge clk);
      check_result("t1", 7, 2);
      chk("t1_busy_low", bus.busy, 0);
      repeat (10) @(negedge clk);
      check_result("t1_hold", 7, 2);

      run_op("t2a", 2, 5);
      run_op("t2b", 6, 3);
      run_op("t3", 5, 0);

      // 7/3 with an ignored start for 1/1 during RUN
      bus.start = 1'b1; bus.dividend = 3'd7; bus.divisor = 3'd3;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 3'd1; bus.divisor = 3'd1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check_result("t4", 7, 3);
      @(negedge clk);
      check_result("t4_stay", 7, 3);

      // reset during RUN, then start held across reset release
      bus.start = 1'b1; bus.dividend = 3'd7; bus.divisor = 3'd2;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", bus.out_valid, 0);
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_ready", bus.in_ready, 1);
      chk("t5_rst_q", bus.quotient, 0);
      chk("t5_rst_r", bus.remainder, 0);
      chk("t5_rst_dbz", bus.div_by_zero, 0);
      bus.start = 1'b1; bus.dividend = 3'd4; bus.divisor = 3'd2;
      @(negedge clk);
      chk("t5_held_busy", bus.busy, 0);
      rst = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t5_acc_busy", bus.busy, 1);
      chk("t5_acc_valid", bus.out_valid, 0);
      wait_done(lat);
      chk("t5_latency", lat, W);
      check_result("t5", 4, 2);

      // random operands
      for (int k = 0; k < 20; k++) begin
         run_op("rand", int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)));
      end

      // exhaustive back-to-back sweep with start held high
      bus.start = 1'b1; bus.dividend = 3'd0; bus.divisor = 3'd0;
      for (int k = 0; k <= ONES * (ONES + 2); k++) begin
         int a;
         int b;
         a = k % (ONES + 1);
         b = k / (ONES + 1);
         wait_done(lat);
         chk("sweep_latency", lat, W + 1);
         check_result("sweep", a, b);
         if (k < ONES * (ONES + 2)) begin
            bus.dividend = W'((k + 1) % (ONES + 1));
            bus.divisor  = W'((k + 1) / (ONES + 1));
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
      check_result("sweep_end_hold", ONES, ONES);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
